// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// reset_sequencer: ordered per-domain reset release with software re-sequence
// Rev 1.0
// ---------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_STAGES        = 4,
  parameter int MIN_ASSERT_CYCLES = 8,
  parameter int GAP_CYCLES        = 16,
  parameter int DLY               = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_sync_i,
  input  logic                  sw_rst_req_i,
  output logic                  sw_rst_ack_o,
  output logic [NUM_STAGES-1:0] rst_n_stage_o,
  output logic                  seq_busy_o,
  output logic                  seq_done_o
);

  // DLY only affects simulation timing and folds to zero here.
  localparam int CNT_TOP = ((MIN_ASSERT_CYCLES > GAP_CYCLES) ? MIN_ASSERT_CYCLES : GAP_CYCLES) + 0 * DLY;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam int IW      = $clog2(NUM_STAGES + 1);

  localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_ASSERT_CYCLES);
  localparam logic [CW-1:0] GAP_CNT  = CW'(GAP_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN, ACK} state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d, cnt_inc;
  logic [IW-1:0]           idx, idx_d;
  logic [NUM_STAGES-1:0]   stage, stage_d;
  logic                    ack, ack_d;
  logic                    done, done_d;
  logic                    busy, busy_d;
  logic                    pend, pend_d;

  always_ff @(posedge clk_i or negedge rst_n_sync_i) begin
    if (!rst_n_sync_i) begin
      state <= HOLD;
      cnt   <= '0;
      idx   <= '0;
      stage <= '0;
      ack   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b1;
      pend  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      stage <= stage_d;
      ack   <= ack_d;
      done  <= done_d;
      busy  <= busy_d;
      pend  <= pend_d;
    end
  end

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    stage_d = stage;
    ack_d   = ack;
    done_d  = done;
    busy_d  = busy;
    pend_d  = pend;
    case (state)
      HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_inc == MIN_CNT) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == GAP_CNT) begin
          cnt_d = '0;
          idx_d = idx + IW'(1);
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx == IW'(k)) stage_d[k] = 1'b1;
          end
          if (idx == LAST_IDX) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            // A software-initiated sequence finishes with the acknowledge.
            if (pend) begin
              ack_d   = 1'b1;
              pend_d  = 1'b0;
              state_d = ACK;
            end else begin
              state_d = RUN;
            end
          end
        end
      end
      RUN: begin
        if (sw_rst_req_i && !ack) begin
          stage_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b1;
          state_d = HOLD;
        end
      end
      ACK: begin
        if (!sw_rst_req_i) begin
          ack_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign sw_rst_ack_o  = ack;
  assign rst_n_stage_o = stage;
  assign seq_busy_o    = busy;
  assign seq_done_o    = done;

endmodule
`default_nettype wire
